// File: rtl/rtc_pkg.sv
// Shared constants for the BCD real-time clock: digit limits, segment codes
// and the BCD-to-seven-segment decode function.
package rtc_pkg;

    localparam logic [3:0] SEC_L_MAX  = 4'd9;
    localparam logic [3:0] SEC_M_MAX  = 4'd5;
    localparam logic [3:0] MIN_L_MAX  = 4'd9;
    localparam logic [3:0] MIN_M_MAX  = 4'd5;
    localparam logic [3:0] HOUR_L_MAX = 4'd9;
    localparam logic [3:0] HOUR_M_MAX = 4'd2;
    localparam logic [3:0] DAY_HOUR_M = 4'd2;
    localparam logic [3:0] DAY_HOUR_L = 4'd3;

    // bit0=a .. bit6=g, active-high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7.sv
// Standalone combinational BCD to seven-segment decoder.
module seg7
    import rtc_pkg::*;
(
    input  logic [3:0] data_in,
    output logic [6:0] display_out
);

    always_comb begin
        display_out = rtc_pkg::seg7(data_in);
    end

endmodule

// File: rtl/universal_counter.sv
// Modulo-(MAX+1) BCD digit counter with async active-low reset and a
// synchronous clear that takes priority over the count enable.
module universal_counter #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] Count
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            // >= so an out-of-range value also wraps to 0 on its next enable
            count_d = (count_q >= MAX) ? '0 : count_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign Count = count_q;

endmodule

// File: rtl/real_tym_clock.sv
// 24-hour HH:MM:SS BCD clock, one second per clk edge, driving six
// seven-segment digits through per-digit decoders.
module real_tym_clock
    import rtc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [6:0] Sec_L,
    output logic [6:0] Sec_M,
    output logic [6:0] Min_L,
    output logic [6:0] Min_M,
    output logic [6:0] Hour_L,
    output logic [6:0] Hour_M
);

    logic [3:0] s_l, s_m, m_l, m_m, h_l, h_m;
    logic       s_m_en, m_l_en, m_m_en, h_l_en, h_m_en, day_clr;

    // Whole carry chain is combinational so every rollover lands on one edge.
    always_comb begin
        s_m_en  = (s_l == SEC_L_MAX);
        m_l_en  = (s_m == SEC_M_MAX) && (s_l == SEC_L_MAX);
        m_m_en  = (m_l == MIN_L_MAX) && m_l_en;
        h_l_en  = (m_m == MIN_M_MAX) && m_m_en;
        h_m_en  = (h_l == HOUR_L_MAX) && h_l_en;
        day_clr = (h_m == DAY_HOUR_M) && (h_l == DAY_HOUR_L) && h_l_en;
    end

    universal_counter #(.MAX(SEC_L_MAX)) u_sec_l (
        .clk(clk), .rst(rst), .clr(1'b0), .en(1'b1), .Count(s_l)
    );
    universal_counter #(.MAX(SEC_M_MAX)) u_sec_m (
        .clk(clk), .rst(rst), .clr(1'b0), .en(s_m_en), .Count(s_m)
    );
    universal_counter #(.MAX(MIN_L_MAX)) u_min_l (
        .clk(clk), .rst(rst), .clr(1'b0), .en(m_l_en), .Count(m_l)
    );
    universal_counter #(.MAX(MIN_M_MAX)) u_min_m (
        .clk(clk), .rst(rst), .clr(1'b0), .en(m_m_en), .Count(m_m)
    );
    universal_counter #(.MAX(HOUR_L_MAX)) u_hour_l (
        .clk(clk), .rst(rst), .clr(day_clr), .en(h_l_en), .Count(h_l)
    );
    universal_counter #(.MAX(HOUR_M_MAX)) u_hour_m (
        .clk(clk), .rst(rst), .clr(day_clr), .en(h_m_en), .Count(h_m)
    );

    seg7 u_seg_sec_l  (.data_in(s_l), .display_out(Sec_L));
    seg7 u_seg_sec_m  (.data_in(s_m), .display_out(Sec_M));
    seg7 u_seg_min_l  (.data_in(m_l), .display_out(Min_L));
    seg7 u_seg_min_m  (.data_in(m_m), .display_out(Min_M));
    seg7 u_seg_hour_l (.data_in(h_l), .display_out(Hour_L));
    seg7 u_seg_hour_m (.data_in(h_m), .display_out(Hour_M));

endmodule

// File: tb/tb_real_tym_clock.sv
// Directed bench for real_tym_clock: reset, carries through seconds,
// minutes, hours, the day wrap, and a standalone decoder sweep.
module tb_real_tym_clock;

    logic       clk;
    logic       rst;
    logic [6:0] Sec_L, Sec_M, Min_L, Min_M, Hour_L, Hour_M;
    logic [3:0] dec_in;
    logic [6:0] dec_out;

    int unsigned total;
    int unsigned bad;

    real_tym_clock dut (
        .clk(clk), .rst(rst),
        .Sec_L(Sec_L), .Sec_M(Sec_M), .Min_L(Min_L),
        .Min_M(Min_M), .Hour_L(Hour_L), .Hour_M(Hour_M)
    );

    seg7 u_dec (.data_in(dec_in), .display_out(dec_out));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Display as {Hour_M, Hour_L, Min_M, Min_L, Sec_M, Sec_L}
    function automatic logic [41:0] disp();
        return {Hour_M, Hour_L, Min_M, Min_L, Sec_M, Sec_L};
    endfunction

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        tick(2);
        total++;
        if (disp() !== {6{7'h3F}}) begin
            bad++;
            $display("FAIL reset_hold: got %h want %h", disp(), {6{7'h3F}});
        end
        @(negedge clk);
        rst = 1'b1;
        tick(5);
        total++;
        if (Sec_L !== 7'h6D) begin
            bad++;
            $display("FAIL count_5: got %h want %h", Sec_L, 7'h6D);
        end
        // assert reset between edges; no clock edge before the check
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (disp() !== {6{7'h3F}}) begin
            bad++;
            $display("FAIL reset_async: got %h want %h", disp(), {6{7'h3F}});
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_seconds();
        do_reset();
        tick(9);
        total++;
        if ({Sec_M, Sec_L} !== {7'h3F, 7'h6F}) begin
            bad++;
            $display("FAIL sec_9: got %h want %h", {Sec_M, Sec_L}, {7'h3F, 7'h6F});
        end
        tick(1);
        total++;
        if ({Sec_M, Sec_L} !== {7'h06, 7'h3F}) begin
            bad++;
            $display("FAIL sec_10: got %h want %h", {Sec_M, Sec_L}, {7'h06, 7'h3F});
        end
    endtask

    task automatic test_minute();
        do_reset();
        tick(59);
        total++;
        if (disp() !== {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h6D, 7'h6F}) begin
            bad++;
            $display("FAIL sec_59: got %h want %h", disp(),
                     {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h6D, 7'h6F});
        end
        tick(1);
        total++;
        if (disp() !== {7'h3F, 7'h3F, 7'h3F, 7'h06, 7'h3F, 7'h3F}) begin
            bad++;
            $display("FAIL min_1: got %h want %h", disp(),
                     {7'h3F, 7'h3F, 7'h3F, 7'h06, 7'h3F, 7'h3F});
        end
    endtask

    // Runs one continuous day from reset: hour carry, 09:59:59 -> 10:00:00,
    // 23:59:59 -> 00:00:00 and the first second of the new day.
    task automatic test_hours_and_day_wrap();
        do_reset();
        tick(3599);
        total++;
        if (disp() !== {7'h3F, 7'h3F, 7'h6D, 7'h6F, 7'h6D, 7'h6F}) begin
            bad++;
            $display("FAIL t_00_59_59: got %h want %h", disp(),
                     {7'h3F, 7'h3F, 7'h6D, 7'h6F, 7'h6D, 7'h6F});
        end
        tick(1);
        total++;
        if (disp() !== {7'h3F, 7'h06, 7'h3F, 7'h3F, 7'h3F, 7'h3F}) begin
            bad++;
            $display("FAIL t_01_00_00: got %h want %h", disp(),
                     {7'h3F, 7'h06, 7'h3F, 7'h3F, 7'h3F, 7'h3F});
        end
        tick(35999 - 3600);
        total++;
        if (disp() !== {7'h3F, 7'h6F, 7'h6D, 7'h6F, 7'h6D, 7'h6F}) begin
            bad++;
            $display("FAIL t_09_59_59: got %h want %h", disp(),
                     {7'h3F, 7'h6F, 7'h6D, 7'h6F, 7'h6D, 7'h6F});
        end
        tick(1);
        total++;
        if (disp() !== {7'h06, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F}) begin
            bad++;
            $display("FAIL t_10_00_00: got %h want %h", disp(),
                     {7'h06, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F});
        end
        tick(72000 - 36000);
        total++;
        if (disp() !== {7'h5B, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F}) begin
            bad++;
            $display("FAIL t_20_00_00: got %h want %h", disp(),
                     {7'h5B, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F});
        end
        tick(86399 - 72000);
        total++;
        if (disp() !== {7'h5B, 7'h4F, 7'h6D, 7'h6F, 7'h6D, 7'h6F}) begin
            bad++;
            $display("FAIL t_23_59_59: got %h want %h", disp(),
                     {7'h5B, 7'h4F, 7'h6D, 7'h6F, 7'h6D, 7'h6F});
        end
        tick(1);
        total++;
        if (disp() !== {6{7'h3F}}) begin
            bad++;
            $display("FAIL day_wrap: got %h want %h", disp(), {6{7'h3F}});
        end
        tick(1);
        total++;
        if (disp() !== {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h06}) begin
            bad++;
            $display("FAIL t_00_00_01: got %h want %h", disp(),
                     {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h06});
        end
    endtask

    task automatic test_decoder();
        logic [6:0] exp_tab [16];
        exp_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
        for (int i = 0; i < 16; i++) begin
            dec_in = 4'(i);
            #1;
            total++;
            if (dec_out !== exp_tab[i]) begin
                bad++;
                $display("FAIL seg7_%0d: got %h want %h", i, dec_out, exp_tab[i]);
            end
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        dec_in = '0;
        test_reset();
        test_seconds();
        test_minute();
        test_hours_and_day_wrap();
        test_decoder();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
